fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 26 ++
 rtl/fetch_queue_if.sv | 44 ++++
 rtl/defines.v | 14 +
 rtl/fetch_queue_fifo_ram.sv | 34 +++
 rtl/fetch_queue.sv | 96 +++++++++
 tb/tb_fetch_queue.sv | 192 +++++++++++++++++++
 6 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  fetch_queue_pkg
//  Shared widths, queue entry layout and PC arithmetic for the fetch queue.
//  Rev 1.0 - initial release
// ============================================================================
`include "defines.v"

package fetch_queue_pkg;

  localparam int INST_W = `Inst_Width;
  localparam int ADDR_W = `Inst_Addr_Width;

  // One queue entry: the PC it was fetched from plus the instruction word.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  // Sequential fetch step; wraps naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  fetch_queue_if
//  Cache, redirect and dequeue signals between the fetch queue and its
//  neighbours. master = fetch_queue side, slave = environment side.
//  Rev 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  import fetch_queue_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // instruction cache
  logic              cache_ce;
  logic [ADDR_W-1:0] cache_addr;
  logic              pc_cache_stall;
  logic [INST_W-1:0] cache_inst;
  logic              cache_enable;
  // redirect from commit
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  // issue side
  logic              deq_valid;
  logic              deq_ready;
  logic [INST_W-1:0] deq_inst;
  logic [ADDR_W-1:0] deq_pc;
  logic [CNT_W-1:0]  count;

  modport master (
    output cache_ce, cache_addr, pc_cache_stall,
    output deq_valid, deq_inst, deq_pc, count,
    input  cache_inst, cache_enable, redirect_valid, redirect_pc, deq_ready
  );

  modport slave (
    input  cache_ce, cache_addr, pc_cache_stall,
    input  deq_valid, deq_inst, deq_pc, count,
    output cache_inst, cache_enable, redirect_valid, redirect_pc, deq_ready
  );

endinterface
`default_nettype wire

// File: rtl/defines.v
`default_nettype none
// ============================================================================
//  defines.v
//  Global instruction and instruction-address widths for the fetch path.
//  Rev 1.0 - initial release
// ============================================================================
`ifndef FETCH_QUEUE_DEFINES_V
`define FETCH_QUEUE_DEFINES_V

`define Inst_Width      32
`define Inst_Addr_Width 32

`endif
`default_nettype wire

// File: rtl/fetch_queue_fifo_ram.sv
`default_nettype none
// ============================================================================
//  fifo_ram
//  DEPTH-entry storage for the fetch queue: synchronous write, asynchronous
//  read. No reset; occupancy tracking lives in the controller.
//  Rev 1.0 - initial release
// ============================================================================
module fifo_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          we,
  input  wire logic [AW-1:0] waddr,
  input  wire entry_t        wdata,
  input  wire logic [AW-1:0] raddr,
  output entry_t             rdata
);

  entry_t mem [DEPTH];

  // Write the tail entry on the clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  fetch_queue
//  Fetch PC generator and instruction queue in front of issue. Fetches from
//  a combinational cache, buffers {pc, inst} pairs and flushes on redirect.
//  Rev 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input wire logic     clk,
  input wire logic     rst_n,
  fetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc;
  logic              cache_ce;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  logic   full;
  logic   deq_valid;
  logic   pop;
  logic   stall;
  logic   push;
  entry_t wr_entry;
  entry_t rd_entry;

  // Handshake decode. A redirect hides the head and blocks the cache read;
  // a full queue only stalls fetch when nothing is leaving this cycle.
  assign full      = (count == CNT_W'(DEPTH));
  assign deq_valid = (count != '0) && !bus.redirect_valid;
  assign pop       = deq_valid && bus.deq_ready;
  assign stall     = bus.redirect_valid || (full && !pop);
  assign push      = cache_ce && !stall && bus.cache_enable;

  assign wr_entry.pc   = pc;
  assign wr_entry.inst = bus.cache_inst;

  // PC, cache enable, pointers and occupancy. Redirect flushes the queue;
  // a miss (cache_enable low) holds the PC so fetch waits for a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      cache_ce <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      cache_ce <= 1'b1;
      if (bus.redirect_valid) begin
        pc    <= bus.redirect_pc;
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) begin
          tail <= tail + PTR_W'(1);
          pc   <= next_pc(pc);
        end
        if (pop) begin
          head <= head + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (rd_entry)
  );

  assign bus.cache_ce       = cache_ce;
  assign bus.cache_addr     = pc;
  assign bus.pc_cache_stall = stall;
  assign bus.deq_valid      = deq_valid;
  assign bus.deq_inst       = rd_entry.inst;
  assign bus.deq_pc         = rd_entry.pc;
  assign bus.count          = count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  tb_fetch_queue
//  Directed bench for fetch_queue (DEPTH=4, RESET_PC=0) with a combinational
//  cache model whose instruction word is derived from the fetch address.
//  Rev 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  fetch_queue_if #(.DEPTH(4)) bus ();

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC ('0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational cache: instruction word is a fixed scramble of the address.
  assign bus.cache_inst = INST_W'(bus.cache_addr) ^ INST_W'(32'hC0DE_0000);

  function automatic logic [63:0] exp_inst(input logic [63:0] addr);
    return (addr ^ 64'hC0DE_0000) & 64'hFFFF_FFFF;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n              = 1'b0;
    bus.cache_enable   = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.deq_ready      = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_count", 64'(bus.count), 0);
    check_val("rst_ce", 64'(bus.cache_ce), 0);
    check_val("rst_deq_valid", 64'(bus.deq_valid), 0);
    check_val("rst_stall", 64'(bus.pc_cache_stall), 0);
    check_val("rst_addr", 64'(bus.cache_addr), 0);

    // streaming: one instruction per cycle from the third cycle
    rst_n = 1'b1;
    bus.deq_ready    = 1'b1;
    bus.cache_enable = 1'b1;
    tick();
    check_val("st_ce", 64'(bus.cache_ce), 1);
    check_val("st_count0", 64'(bus.count), 0);
    tick();
    check_val("st_valid", 64'(bus.deq_valid), 1);
    check_val("st_pc0", 64'(bus.deq_pc), 0);
    check_val("st_inst0", 64'(bus.deq_inst), exp_inst(0));
    check_val("st_count1", 64'(bus.count), 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_val("st_pc", 64'(bus.deq_pc), 64'(4 * i));
      check_val("st_stall", 64'(bus.pc_cache_stall), 0);
      check_val("st_count", 64'(bus.count), 1);
    end

    // flush to PC 0 and fill with issue blocked
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = '0;
    bus.deq_ready      = 1'b0;
    #1;
    check_val("rd_hide_valid", 64'(bus.deq_valid), 0);
    check_val("rd_stall", 64'(bus.pc_cache_stall), 1);
    tick();
    bus.redirect_valid = 1'b0;
    check_val("rd_count", 64'(bus.count), 0);
    check_val("rd_addr", 64'(bus.cache_addr), 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_val("fill_count", 64'(bus.count), 64'(i));
    end
    check_val("full_stall", 64'(bus.pc_cache_stall), 1);
    check_val("full_addr", 64'(bus.cache_addr), 64'h10);
    check_val("full_head", 64'(bus.deq_pc), 0);
    tick();
    check_val("full_hold_count", 64'(bus.count), 4);
    check_val("full_hold_addr", 64'(bus.cache_addr), 64'h10);

    // push + pop at full
    bus.deq_ready = 1'b1;
    #1;
    check_val("fpp_stall", 64'(bus.pc_cache_stall), 0);
    tick();
    bus.deq_ready = 1'b0;
    check_val("fpp_count", 64'(bus.count), 4);
    check_val("fpp_head", 64'(bus.deq_pc), 4);
    check_val("fpp_addr", 64'(bus.cache_addr), 64'h14);

    // pop only (cache miss) to reach count 3, then redirect to 0x40
    bus.deq_ready    = 1'b1;
    bus.cache_enable = 1'b0;
    tick();
    bus.deq_ready    = 1'b0;
    bus.cache_enable = 1'b1;
    check_val("pop_count", 64'(bus.count), 3);
    check_val("pop_head", 64'(bus.deq_pc), 8);
    check_val("miss_addr", 64'(bus.cache_addr), 64'h14);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    #1;
    check_val("r40_hide", 64'(bus.deq_valid), 0);
    tick();
    bus.redirect_valid = 1'b0;
    check_val("r40_count", 64'(bus.count), 0);
    check_val("r40_valid", 64'(bus.deq_valid), 0);
    check_val("r40_addr", 64'(bus.cache_addr), 64'h40);
    tick();
    check_val("r40_valid1", 64'(bus.deq_valid), 1);
    check_val("r40_pc", 64'(bus.deq_pc), 64'h40);
    check_val("r40_inst", 64'(bus.deq_inst), exp_inst(64'h40));

    // fetch halts on a miss at 0x8, resumes after redirect to 0
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8;
    tick();
    bus.redirect_valid = 1'b0;
    bus.cache_enable   = 1'b0;
    check_val("miss_count0", 64'(bus.count), 0);
    check_val("miss_addr0", 64'(bus.cache_addr), 8);
    tick();
    tick();
    check_val("miss_count2", 64'(bus.count), 0);
    check_val("miss_addr2", 64'(bus.cache_addr), 8);
    check_val("miss_stall", 64'(bus.pc_cache_stall), 0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = '0;
    bus.cache_enable   = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check_val("res_count", 64'(bus.count), 1);
    check_val("res_pc", 64'(bus.deq_pc), 0);
    check_val("res_addr", 64'(bus.cache_addr), 4);

    // asynchronous reset mid-stream with two entries queued
    tick();
    bus.cache_enable = 1'b0;
    check_val("pre_rst_count", 64'(bus.count), 2);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("arst_count", 64'(bus.count), 0);
    check_val("arst_ce", 64'(bus.cache_ce), 0);
    check_val("arst_valid", 64'(bus.deq_valid), 0);
    check_val("arst_addr", 64'(bus.cache_addr), 0);
    tick();
    rst_n = 1'b1;
    bus.cache_enable = 1'b1;
    bus.deq_ready    = 1'b1;
    tick();
    check_val("rr_ce", 64'(bus.cache_ce), 1);
    check_val("rr_count", 64'(bus.count), 0);
    tick();
    check_val("rr_valid", 64'(bus.deq_valid), 1);
    check_val("rr_pc", 64'(bus.deq_pc), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
